// File: rtl/ttt_pkg.sv
// ttt_pkg: cell/status encodings, FSM states, command codes and the win-line table
// shared by ttt_frame_ctrl and ttt_win_check.
package ttt_pkg;
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] STAT_PLAY = 2'b00;
    localparam logic [1:0] STAT_XWIN = 2'b01;
    localparam logic [1:0] STAT_OWIN = 2'b10;
    localparam logic [1:0] STAT_DRAW = 2'b11;

    localparam logic [3:0] CURSOR_CENTRE = 4'd4;

    typedef enum logic [2:0] {S_PLAY, S_PEND, S_COMMIT, S_CHECK, S_DONE} state_t;
    typedef enum logic [2:0] {CMD_RIGHT, CMD_LEFT, CMD_DOWN, CMD_UP, CMD_ENTER} cmd_t;

    // rows 0-2, cols 3-5, main diagonal 6, anti-diagonal 7
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] cell_of(input logic [17:0] board, input logic [3:0] idx);
        return board[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [3:0] move_cursor(input logic [3:0] c, input cmd_t cmd);
        logic left_col, right_col;
        left_col  = c == 4'd0 || c == 4'd3 || c == 4'd6;
        right_col = c == 4'd2 || c == 4'd5 || c == 4'd8;
        return cmd == CMD_UP    ? (c < 4'd3 ? c + 4'd6 : c - 4'd3) :
               cmd == CMD_DOWN  ? (c > 4'd5 ? c - 4'd6 : c + 4'd3) :
               cmd == CMD_LEFT  ? (left_col ? c + 4'd2 : c - 4'd1) :
               cmd == CMD_RIGHT ? (right_col ? c - 4'd2 : c + 4'd1) : c;
    endfunction
endpackage

// File: rtl/ttt_win_check.sv
// ttt_win_check: combinational evaluation of the 8 lines and board fullness;
// lines is the one-hot mask of the lowest-index completed line.
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [17:0] cells,
    output logic        x_win,
    output logic        o_win,
    output logic        full,
    output logic [7:0]  lines
);
    logic [7:0] x_lines, o_lines, any_lines;

    always_comb begin
        x_lines = '0;
        o_lines = '0;
        full    = 1'b1;
        for (int l = 0; l < 8; l++) begin
            x_lines[l] = cell_of(cells, WIN_LINES[l][0]) == CELL_X &&
                         cell_of(cells, WIN_LINES[l][1]) == CELL_X &&
                         cell_of(cells, WIN_LINES[l][2]) == CELL_X;
            o_lines[l] = cell_of(cells, WIN_LINES[l][0]) == CELL_O &&
                         cell_of(cells, WIN_LINES[l][1]) == CELL_O &&
                         cell_of(cells, WIN_LINES[l][2]) == CELL_O;
        end
        for (int i = 0; i < 9; i++)
            full = full & (cell_of(cells, 4'(i)) != CELL_EMPTY);
    end

    assign any_lines = x_lines | o_lines;
    assign x_win     = |x_lines;
    assign o_win     = |o_lines;
    assign lines     = any_lines & (~any_lines + 8'd1);
endmodule

// File: rtl/ttt_frame_ctrl.sv
// ttt_frame_ctrl: tic-tac-toe controller that commits key commands only at vsync_start.
// Optional macro TTT_WIN_HILITE_EN adds the win_line highlight output.
module ttt_frame_ctrl
    import ttt_pkg::*;
#(
    parameter int HOLD_FRAMES = 120
) (
    input  logic        mclk,
    input  logic        clr,
    input  logic        vsync_start,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_enter,
    output logic [17:0] cells,
    output logic [3:0]  cursor,
    output logic        turn,
    output logic [1:0]  status,
    output logic        busy
`ifdef TTT_WIN_HILITE_EN
    ,
    output logic [7:0]  win_line
`endif
);
    state_t     state;
    cmd_t       cmd, key_cmd;
    logic       cmd_valid, key_any, can_load, place, game_over, draw, hold_hit;
    logic       x_win, o_win, full;
    logic [7:0] lines, frames, next_frames;
    logic [1:0] mark, result;

    ttt_win_check win_check (
        .cells(cells),
        .x_win(x_win),
        .o_win(o_win),
        .full(full),
        .lines(lines)
    );

    assign key_any  = key_up | key_down | key_left | key_right | key_enter;
    assign key_cmd  = key_enter ? CMD_ENTER : key_up ? CMD_UP : key_down ? CMD_DOWN :
                      key_left ? CMD_LEFT : CMD_RIGHT;
    // a pending enter is sticky; pending arrows are overwritten by newer keys
    assign can_load = key_any && !(cmd_valid && cmd == CMD_ENTER);
    assign mark     = turn ? CELL_O : CELL_X;
    assign place    = cmd == CMD_ENTER && cell_of(cells, cursor) == CELL_EMPTY;
    assign game_over = x_win | o_win | full;
    assign draw     = full & ~|lines;
    assign result   = draw ? STAT_DRAW : x_win ? STAT_XWIN : STAT_OWIN;
    assign next_frames = frames == 8'hFF ? frames : frames + 8'd1;
    assign hold_hit = next_frames == 8'(HOLD_FRAMES);

    always_ff @(posedge mclk) begin
        if (clr) begin
            state     <= S_PLAY;
            cmd       <= CMD_RIGHT;
            cmd_valid <= 1'b0;
            frames    <= '0;
            cells     <= '0;
            cursor    <= CURSOR_CENTRE;
            turn      <= 1'b0;
            status    <= STAT_PLAY;
            busy      <= 1'b0;
`ifdef TTT_WIN_HILITE_EN
            win_line  <= '0;
`endif
        end else begin
            case (state)
                S_PLAY: if (key_any) begin
                    cmd       <= key_cmd;
                    cmd_valid <= 1'b1;
                    busy      <= 1'b1;
                    state     <= S_PEND;
                end
                S_PEND: if (vsync_start) begin
                    cursor <= move_cursor(cursor, cmd);
                    if (place)
                        cells[{cursor, 1'b0} +: 2] <= mark;
                    state     <= place ? S_CHECK : S_COMMIT;
                    // a key on the vsync cycle waits for the next frame
                    cmd       <= key_cmd;
                    cmd_valid <= key_any;
                end else if (can_load) begin
                    cmd <= key_cmd;
                end
                S_COMMIT, S_CHECK: if (state == S_CHECK && game_over) begin
                    status    <= result;
`ifdef TTT_WIN_HILITE_EN
                    win_line  <= lines;
`endif
                    frames    <= '0;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_DONE;
                end else begin
                    if (state == S_CHECK)
                        turn <= ~turn;
                    if (can_load) begin
                        cmd       <= key_cmd;
                        cmd_valid <= 1'b1;
                    end
                    busy  <= cmd_valid | key_any;
                    state <= cmd_valid | key_any ? S_PEND : S_PLAY;
                end
                S_DONE: if (vsync_start) begin
                    frames <= next_frames;
                    if (cmd_valid || hold_hit) begin
                        cells     <= '0;
                        cursor    <= CURSOR_CENTRE;
                        turn      <= 1'b0;
                        status    <= STAT_PLAY;
                        busy      <= 1'b0;
                        cmd_valid <= 1'b0;
`ifdef TTT_WIN_HILITE_EN
                        win_line  <= '0;
`endif
                        state     <= S_PLAY;
                    end else begin
                        cmd_valid <= key_enter;
                        busy      <= key_enter;
                    end
                end else if (key_enter) begin
                    cmd_valid <= 1'b1;
                    busy      <= 1'b1;
                end
                default: state <= S_PLAY;
            endcase
        end
    end
endmodule

// File: tb/tb_ttt_frame_ctrl.sv
// tb_ttt_frame_ctrl: directed game scenarios checked every cycle against a board-level
// model, plus literal expectations; honours TTT_WIN_HILITE_EN.
module tb_ttt_frame_ctrl;
    localparam int HOLD = 3;
    localparam logic [4:0] K_E = 5'b10000, K_U = 5'b01000, K_D = 5'b00100,
                           K_L = 5'b00010, K_R = 5'b00001;

    logic mclk = 1'b0, clr = 1'b1, vsync_start = 1'b0;
    logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_enter = 1'b0;
    logic [17:0] cells;
    logic [3:0]  cursor;
    logic        turn, busy;
    logic [1:0]  status;
`ifdef TTT_WIN_HILITE_EN
    logic [7:0]  win_line;
`endif
    int vectors = 0, miscompares = 0;

    always #5 mclk = ~mclk;

    ttt_frame_ctrl #(.HOLD_FRAMES(HOLD)) dut (
        .mclk(mclk), .clr(clr), .vsync_start(vsync_start),
        .key_up(key_up), .key_down(key_down), .key_left(key_left),
        .key_right(key_right), .key_enter(key_enter),
        .cells(cells), .cursor(cursor), .turn(turn), .status(status), .busy(busy)
`ifdef TTT_WIN_HILITE_EN
        , .win_line(win_line)
`endif
    );

    // model: board as marks (0 empty, 1 X, 2 O), cursor as row*3+col
    int board [9];
    int cur, pend, stage, frames;
    logic mturn, mbusy, chk, done, clr_pend, live = 1'b0;
    logic [1:0] mstat;
    logic [7:0] mline;

    task automatic model_reset();
        foreach (board[i]) board[i] = 0;
        cur = 4; pend = -1; stage = 0; frames = 0;
        mturn = 0; mbusy = 0; chk = 0; done = 0; clr_pend = 0; mstat = 0; mline = 0;
    endtask

    function automatic logic [7:0] lines_of();
        logic [7:0] m;
        m = '0;
        for (int r = 0; r < 3; r++)
            m[r] = board[3*r] != 0 && board[3*r] == board[3*r+1] && board[3*r] == board[3*r+2];
        for (int c = 0; c < 3; c++)
            m[3+c] = board[c] != 0 && board[c] == board[c+3] && board[c] == board[c+6];
        m[6] = board[0] != 0 && board[0] == board[4] && board[0] == board[8];
        m[7] = board[2] != 0 && board[2] == board[4] && board[2] == board[6];
        return m;
    endfunction

    function automatic logic [17:0] exp_cells();
        logic [17:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[2*i +: 2] = 2'(board[i]);
        return v;
    endfunction

    task automatic model_edge(input logic [4:0] k, input logic vs);
        int kk, r, c, low;
        logic [7:0] m;
        logic full;
        kk = -1;
        for (int b = 0; b < 5; b++) if (k[b]) kk = b;
        if (done) begin
            if (vs) begin
                if (frames < 255) frames++;
                if (clr_pend || frames == HOLD) model_reset();
                else begin clr_pend = k[4]; mbusy = k[4]; end
            end else if (k[4]) begin
                clr_pend = 1; mbusy = 1;
            end
        end else if (stage == 1) begin
            stage = 0;
            if (chk) begin
                m = lines_of();
                full = 1;
                foreach (board[i]) if (board[i] == 0) full = 0;
                if (m != 0 || full) begin
                    low = 0;
                    for (int i = 7; i >= 0; i--) if (m[i]) low = i;
                    mstat = m != 0 ? (mturn ? 2'd2 : 2'd1) : 2'd3;
                    mline = m != 0 ? 8'(1) << low : 8'd0;
                    done = 1; frames = 0; pend = -1; mbusy = 0;
                    return;
                end
                mturn = ~mturn;
            end
            if (kk >= 0 && pend != 4) pend = kk;
            mbusy = pend >= 0;
        end else if (pend >= 0 && vs) begin
            r = cur / 3; c = cur % 3; chk = 0;
            case (pend)
                0: c = (c + 1) % 3;
                1: c = (c + 2) % 3;
                2: r = (r + 1) % 3;
                3: r = (r + 2) % 3;
                default: begin
                    chk = board[cur] == 0;
                    if (chk) board[cur] = mturn ? 2 : 1;
                end
            endcase
            cur = r * 3 + c;
            pend = kk;
            stage = 1;
        end else if (kk >= 0 && pend != 4) begin
            pend = kk; mbusy = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge mclk) if (live) begin
        check("m_cells", 32'(cells), 32'(exp_cells()));
        check("m_cursor", 32'(cursor), 32'(cur));
        check("m_turn", 32'(turn), 32'(mturn));
        check("m_status", 32'(status), 32'(mstat));
        check("m_busy", 32'(busy), 32'(mbusy));
`ifdef TTT_WIN_HILITE_EN
        check("m_win_line", 32'(win_line), 32'(mline));
`endif
    end

    task automatic step(input logic [4:0] k, input logic vs);
        {key_enter, key_up, key_down, key_left, key_right} = k;
        vsync_start = vs;
        @(posedge mclk); #1;
        {key_enter, key_up, key_down, key_left, key_right} = 5'b0;
        vsync_start = 1'b0;
        model_edge(k, vs);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        @(posedge mclk); #1;
        clr = 1'b0;
        model_reset();
        live = 1'b1;
    endtask

    task automatic frame(input logic [4:0] k);
        step(k, 0); step(0, 1); step(0, 0); step(0, 0);
    endtask

    task automatic play(input int t);
        while (cur / 3 != t / 3) frame(K_D);
        while (cur % 3 != t % 3) frame(K_R);
        frame(K_E);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_cells", 32'(cells), 32'h0);
        check("rst_cursor", 32'(cursor), 32'd4);
        check("rst_turn", 32'(turn), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        // row wrap 4 -> 5 -> 3 -> 4
        step(K_R, 0); check("busy_rise", 32'(busy), 32'd1);
        step(0, 1);   check("right1", 32'(cursor), 32'd5); check("busy_v1", 32'(busy), 32'd1);
        step(0, 0);   check("busy_v2", 32'(busy), 32'd0);
        step(0, 0);
        frame(K_R); check("right_wrap", 32'(cursor), 32'd3);
        frame(K_R); check("right3", 32'(cursor), 32'd4);
        // X at centre
        step(K_E, 0); step(0, 1);
        check("x_cell_v1", 32'(cells[9:8]), 32'd1); check("turn_v1", 32'(turn), 32'd0);
        step(0, 0); check("turn_v2", 32'(turn), 32'd1);
        step(0, 0);
        frame(K_E); check("reject_cells", 32'(cells), 32'h100); check("reject_turn", 32'(turn), 32'd1);
        // pending arrow overwritten, sticky enter, enter beats up
        step(K_U, 0); step(K_D, 0); step(0, 1); step(0, 0); step(0, 0);
        check("overwrite", 32'(cursor), 32'd7);
        step(K_E, 0); step(K_U, 0); step(0, 1); step(0, 0); step(0, 0);
        check("sticky_cursor", 32'(cursor), 32'd7); check("sticky_o", 32'(cells[15:14]), 32'd2);
        frame(K_E | K_U); check("prio", 32'(cursor), 32'd7);
        // key on a vsync cycle, in PEND and in PLAY
        step(K_R, 0); step(K_L, 1); check("pend_vs", 32'(cursor), 32'd8);
        step(0, 0); step(0, 0); check("latched_busy", 32'(busy), 32'd1);
        step(0, 1); check("latched_left", 32'(cursor), 32'd7);
        step(0, 0); step(0, 0);
        step(K_L, 1); check("late_key", 32'(cursor), 32'd7);
        step(0, 0); step(0, 1); check("late_left", 32'(cursor), 32'd6);
        step(0, 0); step(0, 0);
        // clr while pending discards the command
        step(K_R, 0); do_reset(); step(0, 1);
        check("clr_cursor", 32'(cursor), 32'd4); check("clr_busy", 32'(busy), 32'd0);
        step(0, 0); step(0, 0);
        // X wins on the top row, then auto-clear after HOLD frames
        play(0); play(3); play(1); play(4); play(2);
        check("xwin", 32'(status), 32'd1); check("xwin_cells", 32'(cells), 32'h295);
`ifdef TTT_WIN_HILITE_EN
        check("xwin_line", 32'(win_line), 32'h01);
`endif
        step(K_R, 0); step(0, 1); step(0, 0);
        check("done_arrow", 32'(cursor), 32'd2); check("hold1", 32'(status), 32'd1);
        step(0, 1); step(0, 0); check("hold2", 32'(status), 32'd1);
        step(0, 1);
        check("clear_cells", 32'(cells), 32'h0); check("clear_cursor", 32'(cursor), 32'd4);
        check("clear_status", 32'(status), 32'd0);
        step(0, 0); step(0, 0);
        // full board with no line, then enter clears early
        play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(6); play(8);
        check("draw", 32'(status), 32'd3); check("draw_cells", 32'(cells), 32'h16A59);
        step(K_E, 0); step(0, 1);
        check("enter_clear", 32'(status), 32'd0); check("enter_clear_cells", 32'(cells), 32'h0);
        step(0, 0); step(0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ttt_frame_ctrl.md
# ttt_frame_ctrl

Tic-tac-toe game controller that sequences the VGA display datapath. It owns the 3x3 board, the cursor and turn state, and the game result. It accepts single-cycle key pulses from the input decoder and commits them only at the start of vertical blanking, so the pixel renderer never sees a board change mid-frame. It sits between the keyboard/button front end and the renderer fed by `vga_timer`, all on the 50 MHz pixel clock.

## Interface
Parameters:
- `HOLD_FRAMES`, default 120: number of frames a finished result is held before the board auto-clears; legal range 1..255.

Ports:
- `mclk`  in  1  50 MHz pixel clock; the only clock.
- `clr`  in  1  reset, synchronous and active-high.
- `vsync_start`  in  1  one-cycle pulse at the first cycle of vertical blanking.
- `key_up`, `key_down`, `key_left`, `key_right`, `key_enter`  in  1 each  one-cycle, debounced key pulses.
- `cells`  out  18  board state, 2 bits per cell at `[2i+1:2i]`, where `i = row*3 + col`; 00 = empty, 01 = X, 10 = O.
- `cursor`  out  4  selected cell index, 0..8.
- `turn`  out  1  side to move; 0 = X, 1 = O.
- `status`  out  2  00 = PLAY, 01 = XWIN, 10 = OWIN, 11 = DRAW.
- `busy`  out  1  high while a command is pending or being applied.
- `win_line`  out  8  one-hot winning line; present only with `TTT_WIN_HILITE_EN`.

## Operation
- The FSM has five states: PLAY, PEND, COMMIT, CHECK and DONE.
- **PLAY:** a key pulse loads the one-entry command register, then the FSM moves to PEND.
- **PEND:** waits for `vsync_start`.
  - A later key overwrites a pending arrow.
  - A pending enter is sticky: later keys are dropped until it commits.
  - Priority when several keys pulse in the same cycle: enter > up > down > left > right.
- **COMMIT** (entered on `vsync_start`):
  - Arrows move the cursor one cell and wrap within the row or column (left from col 0 goes to col 2; up from row 0 goes to row 2). The FSM then returns to PLAY.
  - Enter on an empty cell writes the `turn` mark, then the FSM goes to CHECK.
  - Enter on an occupied cell is dropped. Board and turn are unchanged and the FSM returns to PLAY.
- **CHECK:** evaluates the 8 lines (3 rows, 3 cols, 2 diagonals), then picks the next state.
  - A line with three matching marks sets XWIN or OWIN, and the FSM goes to DONE.
  - A full board with no winning line sets DRAW, and the FSM goes to DONE.
  - Otherwise `turn` toggles and the FSM returns to PLAY.
- **DONE:** arrows are ignored. The frame counter counts `vsync_start` pulses.
  - The board clears on the `vsync_start` that brings the count to `HOLD_FRAMES`.
  - An enter clears the board on the next `vsync_start`, whatever the count.
  - Clearing sets `cells` = 0, `cursor` = 4, `turn` = 0 and `status` = PLAY, and returns the FSM to PLAY.
- **Reset values:** `cells` = 0, `cursor` = 4, `turn` = 0, `status` = 00, `busy` = 0, `win_line` = 0, FSM in PLAY, frame counter 0.
- **Reset mid-operation:** `clr` overrides every state, discards the pending command, and takes effect on the next edge.
- **Key on a `vsync_start` cycle:** a key pulse in the same cycle as `vsync_start` is not applied this frame. It is latched and commits on the following `vsync_start`.

## Timing
- A key pulse in cycle t sets `busy` at t+1.
- `vsync_start` in cycle v updates `cells` and `cursor` at v+1.
- `status` and `turn` update at v+2, and `busy` falls at v+2.
- Worst case from key to display is one frame plus 2 cycles.
- All outputs change only in cycles v+1 and v+2, which are inside blanking.
- The frame counter is 8 bits, is cleared on entry to DONE, and saturates rather than wrapping.

## Configuration
- `TTT_WIN_HILITE_EN` defined:
  - `win_line` port exists.
  - In CHECK it is set to the one-hot mask of the winning line: bits 0-2 rows, 3-5 cols, 6 main diagonal, 7 anti-diagonal.
  - If two lines complete at once, the lowest-index line wins.
  - It is cleared when the board clears.
- `TTT_WIN_HILITE_EN` undefined: no `win_line` port and no highlight logic; all other behaviour is identical.

## Structure
- Package `ttt_pkg` holds:
  - cell encodings `CELL_EMPTY`, `CELL_X`, `CELL_O`;
  - status encodings;
  - FSM state enum;
  - `CURSOR_CENTRE` = 4;
  - `WIN_LINES`, an 8x3 table of cell indices.
- Sub-module `ttt_win_check`: combinational; takes the 18-bit board and returns `x_win`, `o_win`, `full` and the 8-bit line mask. The FSM registers its result in CHECK.

## Test plan
- Reset, then `key_right` x3 with a `vsync_start` after each: `cursor` goes 4 → 5 → 3 → 4 (row wrap), and `busy` falls 2 cycles after each `vsync_start`.
- `key_enter` at cursor 4, then `vsync_start`: `cells[9:8]` = 01 at v+1 and `turn` = 1 at v+2.
- A second enter at cursor 4: the command is rejected; `cells` are unchanged and `turn` stays 1.
- Play X at 0, 1, 2 with O at 3, 4: `status` = 01, and `win_line` = 8'h01 when `TTT_WIN_HILITE_EN` is defined.
- With `HOLD_FRAMES` = 3 after a win: the board clears on the 3rd `vsync_start`, giving `cells` = 0, `cursor` = 4, `status` = 00.
- Fill the board with no line: `status` = 11. Also: `key_left` in the same cycle as `vsync_start` takes effect only on the next `vsync_start`, and `clr` while in PEND leaves no commit.
